ddr5_cmd_scheduler: RTL

In-order DDR5 command scheduler. It sits between the trace-request front end (cpu_cyc/core/opn/addr records) and the DRAM command bus. Each accepted request is buffered in a FIFO, decoded with the team address map, and turned into the required PRE/ACT/RD/WR sequence. Per-bank open-row state is tracked, and tRP, tRCD and tCCD spacing is enforced.

---
 rtl/ddr5_cmd_scheduler.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ddr5_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ddr5_cmd_scheduler
// Description : In-order DDR5 command scheduler. Buffers requests in a FIFO
//               and issues PRE/ACT/RD/WR with tRP/tRCD/tCCD spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr5_cmd_scheduler #(
    parameter int ADDR_WIDTH = 34,
    parameter int OPN_WIDTH  = 3,
    parameter int QDEPTH     = 8,
    parameter int T_RP       = 4,
    parameter int T_RCD      = 4,
    parameter int T_CCD      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OPN_WIDTH-1:0]  req_opn,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  cmd_valid,
    output logic [2:0]            cmd_type,
    output logic [2:0]            cmd_bg,
    output logic [1:0]            cmd_ba,
    output logic [15:0]           cmd_row,
    output logic [9:0]            cmd_col,
    output logic                  done_valid,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);

    localparam int c_PTR_W   = $clog2(QDEPTH);
    localparam int c_ENTRY_W = 32;
    localparam int c_WMAX    = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int c_WAIT_W  = $clog2(c_WMAX + 1);
    localparam int c_CCD_W   = $clog2(T_CCD + 1);

    localparam logic [c_WAIT_W-1:0] c_RP_LOAD  = c_WAIT_W'(T_RP - 2);
    localparam logic [c_WAIT_W-1:0] c_RCD_LOAD = c_WAIT_W'(T_RCD - 2);
    localparam logic [c_CCD_W-1:0]  c_CCD_LOAD = c_CCD_W'(T_CCD - 1);

    localparam logic [2:0] c_CMD_NOP = 3'd0;
    localparam logic [2:0] c_CMD_ACT = 3'd1;
    localparam logic [2:0] c_CMD_RD  = 3'd2;
    localparam logic [2:0] c_CMD_WR  = 3'd3;
    localparam logic [2:0] c_CMD_PRE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_PRE      = 3'd2,
        S_WAIT_RP  = 3'd3,
        S_ACT      = 3'd4,
        S_WAIT_RCD = 3'd5,
        S_COL      = 3'd6
    } state_t;

    state_t r_state, w_state_nxt;

    // FIFO entries hold the pre-decoded request: {write, row, col, bg, ba}
    logic [c_ENTRY_W-1:0] r_fifo_mem [QDEPTH];
    logic [c_PTR_W:0]     r_wr_ptr, r_rd_ptr;
    logic                 w_empty, w_full, w_push, w_pop;
    logic [c_ENTRY_W-1:0] w_wr_entry, w_head;

    logic                 r_write;
    logic [15:0]          r_row;
    logic [9:0]           r_col;
    logic [4:0]           r_bank_idx;

    logic [31:0]          r_bank_open;
    logic [15:0]          r_bank_row [32];
    logic                 w_bank_open, w_row_hit;

    logic [c_WAIT_W-1:0]  r_wait;
    logic [c_CCD_W-1:0]   r_ccd;
    logic                 w_col_issue;
    logic                 w_unused_addr;

    assign w_unused_addr = &{1'b0, req_addr[6], req_addr[1:0]};

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;

    assign w_wr_entry = {(req_opn == OPN_WIDTH'(1)), req_addr[33:18],
                         req_addr[17:12], req_addr[5:2], req_addr[9:7], req_addr[11:10]};
    assign w_head     = r_fifo_mem[r_rd_ptr[c_PTR_W-1:0]];

    assign w_bank_open = r_bank_open[r_bank_idx];
    assign w_row_hit   = w_bank_open && (r_bank_row[r_bank_idx] == r_row);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_ACT) begin
            r_bank_row[r_bank_idx] <= r_row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_write     <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_bank_idx  <= '0;
            r_bank_open <= '0;
            r_wait      <= '0;
            r_ccd       <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + (c_PTR_W+1)'(1);
                r_write    <= w_head[31];
                r_row      <= w_head[30:15];
                r_col      <= w_head[14:5];
                r_bank_idx <= w_head[4:0];
            end
            if (r_state == S_DECODE) begin
                if (w_row_hit) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
            // Wait counters are preloaded so the next command lands exactly on tRP/tRCD
            case (r_state)
                S_PRE: begin
                    r_bank_open[r_bank_idx] <= 1'b0;
                    r_wait                  <= c_RP_LOAD;
                end
                S_ACT: begin
                    r_bank_open[r_bank_idx] <= 1'b1;
                    r_wait                  <= c_RCD_LOAD;
                end
                S_WAIT_RP, S_WAIT_RCD: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - c_WAIT_W'(1);
                    end
                end
                default: ;
            endcase
            if (w_col_issue) begin
                r_ccd <= c_CCD_LOAD;
            end else if (r_ccd != '0) begin
                r_ccd <= r_ccd - c_CCD_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_row_hit)        w_state_nxt = S_COL;
                else if (w_bank_open) w_state_nxt = S_PRE;
                else                  w_state_nxt = S_ACT;
            end
            S_PRE:      w_state_nxt = S_WAIT_RP;
            S_WAIT_RP: begin
                if (r_wait == '0) w_state_nxt = S_ACT;
            end
            S_ACT:      w_state_nxt = S_WAIT_RCD;
            S_WAIT_RCD: begin
                if (r_wait == '0) w_state_nxt = S_COL;
            end
            S_COL: begin
                if (r_ccd == '0) w_state_nxt = S_IDLE;
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid   = 1'b0;
        cmd_type    = c_CMD_NOP;
        cmd_bg      = 3'd0;
        cmd_ba      = 2'd0;
        cmd_row     = 16'd0;
        cmd_col     = 10'd0;
        done_valid  = 1'b0;
        w_col_issue = 1'b0;
        case (r_state)
            S_PRE: begin
                cmd_valid = 1'b1;
                cmd_type  = c_CMD_PRE;
                cmd_bg    = r_bank_idx[4:2];
                cmd_ba    = r_bank_idx[1:0];
            end
            S_ACT: begin
                cmd_valid = 1'b1;
                cmd_type  = c_CMD_ACT;
                cmd_bg    = r_bank_idx[4:2];
                cmd_ba    = r_bank_idx[1:0];
                cmd_row   = r_row;
            end
            S_COL: begin
                if (r_ccd == '0) begin
                    cmd_valid   = 1'b1;
                    cmd_type    = r_write ? c_CMD_WR : c_CMD_RD;
                    cmd_bg      = r_bank_idx[4:2];
                    cmd_ba      = r_bank_idx[1:0];
                    cmd_col     = r_col;
                    done_valid  = 1'b1;
                    w_col_issue = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
